// File: rtl/cbrt_dispatch.sv
// cbrt_dispatch: buffers operands in a FIFO and issues them one at a time to the
// cube-root engine, returning each result tagged with its operand on a valid/ready port.
module cbrt_dispatch #(
    parameter int DEPTH       = 4,
    parameter int ARM_TIMEOUT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic                     eng_start,
    output logic [7:0]               eng_x,
    input  logic                     eng_busy,
    input  logic [2:0]               eng_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2:0]               out_result,
    output logic [7:0]               out_x,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               done_cnt,
    output logic                     err
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(ARM_TIMEOUT + 1);
    localparam logic [AW:0]   L_FULL = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] T_LAST = TW'(ARM_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, ARM, RUN} state_t;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_level;
    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic          r_start, r_ov, r_err;
    logic [7:0]    r_x, r_ox, r_done;
    logic [2:0]    r_res;
    logic          w_in_ready, w_push, w_pop;

    assign w_in_ready = r_level < L_FULL;
    assign w_push     = in_valid && w_in_ready;
    assign w_pop      = (r_state == IDLE) && (r_level != '0) && !r_ov;

    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr] <= in_data;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            r_wr    <= w_push ? r_wr + 1'b1 : r_wr;
            r_rd    <= w_pop ? r_rd + 1'b1 : r_rd;
            r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end

    // at most one result outstanding: dispatch waits for out_valid to clear
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_start <= 1'b0;
            r_x     <= '0;
            r_ov    <= 1'b0;
            r_res   <= '0;
            r_ox    <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (r_ov && out_ready) r_ov <= 1'b0;
            case (r_state)
                IDLE: if (w_pop) begin
                    r_x     <= r_mem[r_rd];
                    r_start <= 1'b1;
                    r_state <= ISSUE;
                end
                ISSUE: begin
                    r_start <= 1'b0;
                    r_timer <= '0;
                    r_state <= ARM;
                end
                ARM: if (eng_busy) r_state <= RUN;
                    else if (r_timer == T_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end else r_timer <= r_timer + 1'b1;
                RUN: if (!eng_busy) begin
                    r_res   <= eng_result;
                    r_ox    <= r_x;
                    r_ov    <= 1'b1;
                    r_done  <= r_done + 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end

    assign in_ready   = w_in_ready;
    assign eng_start  = r_start;
    assign eng_x      = r_x;
    assign out_valid  = r_ov;
    assign out_result = r_res;
    assign out_x      = r_ox;
    assign level      = r_level;
    assign done_cnt   = r_done;
    assign err        = r_err;
endmodule
